ex_div_ctrl: RTL and testbench

Sequencer for an iterative radix-2 restoring divider attached to the ex stage. It executes RISC-V DIV/DIVU/REM/REMU. It accepts one request from ex, holds the pipeline via stall_o while iterating, then returns a one-cycle result with its destination register. Flush from pipeline control cancels an in-flight operation.

---
 rtl/ex_div_ctrl.sv | 139 +++++++++++++
 tb/tb_ex_div_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// Sequencer for an iterative radix-2 restoring divider in the ex stage (DIV/DIVU/REM/REMU).
// It latches one request, stalls ex while iterating and returns a one-cycle result.
module ex_div_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cancel_i,
  input  logic              signed_i,
  input  logic              rem_i,
  input  logic [WIDTH-1:0]  opv1,
  input  logic [WIDTH-1:0]  opv2,
  input  logic [ADDR_W-1:0] waddr_i,
  output logic              stall_o,
  output logic              ready_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [ADDR_W-1:0] waddr_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [WIDTH:0]    prem;
  logic [WIDTH-1:0]  quot;
  logic [WIDTH-1:0]  dvsr;
  logic              neg_q, neg_r, rem_sel;
  logic [ADDR_W-1:0] waddr_q;

  logic             accept, a_neg, b_neg, div_zero, ovf, fast, q_bit, last;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res, quot_step, q_fix, r_fix;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   prem_step;

  // Request decode, special cases and one restoring step on the latched magnitudes
  always_comb begin
    accept    = (state == IDLE) && start_i && !cancel_i;
    a_neg     = signed_i && opv1[WIDTH-1];
    b_neg     = signed_i && opv2[WIDTH-1];
    a_mag     = a_neg ? -opv1 : opv1;
    b_mag     = b_neg ? -opv2 : opv2;
    div_zero  = (opv2 == '0);
    ovf       = signed_i && (opv1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&opv2);
    fast      = div_zero || ovf;
    if (div_zero) fast_res = rem_i ? opv1 : '1;
    else          fast_res = rem_i ? '0 : opv1;

    diff      = {prem, quot[WIDTH-1]} - {2'b00, dvsr};
    q_bit     = !diff[WIDTH+1];
    prem_step = q_bit ? diff[WIDTH:0] : {prem[WIDTH-1:0], quot[WIDTH-1]};
    quot_step = {quot[WIDTH-2:0], q_bit};
    q_fix     = neg_q ? -quot_step : quot_step;
    r_fix     = neg_r ? -prem_step[WIDTH-1:0] : prem_step[WIDTH-1:0];
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = fast ? DONE : CALC;
        stall_o = accept;
      end
      CALC: begin
        if (cancel_i)  state_nxt = IDLE;
        else if (last) state_nxt = DONE;
        stall_o = !cancel_i;
      end
      DONE: begin
        state_nxt = IDLE;
        ready_o   = !cancel_i;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall_o = 1'b0;
      ready_o = 1'b0;
    end
  end

  // Results are written only on entry to DONE so they hold until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prem     <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      waddr_q  <= '0;
      result_o <= '0;
      waddr_o  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            waddr_q <= waddr_i;
            rem_sel <= rem_i;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            quot    <= a_mag;
            dvsr    <= b_mag;
            prem    <= '0;
            cnt     <= '0;
            if (fast) begin
              result_o <= fast_res;
              waddr_o  <= waddr_i;
            end
          end
        end
        CALC: begin
          if (cancel_i) begin
            cnt <= '0;
          end else begin
            prem <= prem_step;
            quot <= quot_step;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
              cnt      <= '0;
              result_o <= rem_sel ? r_fix : q_fix;
              waddr_o  <= waddr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed self-checking bench for ex_div_ctrl: latency, results, sign rules,
// special cases, cancel, reset, back-to-back requests and operand isolation.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, cancel_i, signed_i, rem_i;
  logic [31:0] opv1, opv2;
  logic [4:0]  waddr_i;
  logic        stall_o, ready_o;
  logic [31:0] result_o;
  logic [4:0]  waddr_o;

  int testsRun    = 0;
  int testsFailed = 0;

  ex_div_ctrl #(.WIDTH(32), .ADDR_W(5), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cancel_i(cancel_i),
    .signed_i(signed_i), .rem_i(rem_i), .opv1(opv1), .opv2(opv2),
    .waddr_i(waddr_i), .stall_o(stall_o), .ready_o(ready_o),
    .result_o(result_o), .waddr_o(waddr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wa);
    signed_i = s;
    rem_i    = r;
    opv1     = a;
    opv2     = b;
    waddr_i  = wa;
    start_i  = 1'b1;
  endtask

  // Presents a request in the next cycle, holds start until ready, then checks
  // latency, stall during the wait, result and destination. Ends at the ready cycle.
  task automatic runDiv(input string tag, input logic s, input logic r, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic [31:0] expRes,
                        input int expLat, input bit scramble);
    int lat = -1;
    bit stallOk = 1'b1;
    @(posedge clk); #1;
    applyStimulus(s, r, a, b, wa);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = c;
        break;
      end
      if (!stall_o) stallOk = 1'b0;
      @(posedge clk); #1;
      if (scramble) begin
        opv1     = $urandom;
        opv2     = $urandom;
        waddr_i  = 5'($urandom);
        rem_i    = ~rem_i;
        signed_i = ~signed_i;
      end
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_stall_wait"}, {31'd0, stallOk}, 32'd1);
    checkOutput({tag, "_stall_ready"}, {31'd0, stall_o}, 32'd0);
    checkOutput({tag, "_res"}, result_o, expRes);
    checkOutput({tag, "_waddr"}, {27'd0, waddr_o}, {27'd0, wa});
  endtask

  task automatic dropStart(input string tag);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ready_once"}, {31'd0, ready_o}, 32'd0);
    checkOutput({tag, "_stall_idle"}, {31'd0, stall_o}, 32'd0);
  endtask

  task automatic watchNoReady(input string tag, input int n);
    int seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    checkOutput({tag, "_no_ready"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    opv1 = '0; opv2 = '0; waddr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall",  {31'd0, stall_o}, 32'd0);
    checkOutput("rst_ready",  {31'd0, ready_o}, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_waddr",  {27'd0, waddr_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    runDiv("divu_100_7", 0, 0, 32'd100, 32'd7, 5'd5, 32'd14, 33, 0);
    dropStart("divu_100_7");
    runDiv("div_m7_2",   1, 0, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, 0);
    dropStart("div_m7_2");
    runDiv("rem_m7_2",   1, 1, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, 0);
    dropStart("rem_m7_2");
    runDiv("remu_big_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1, 33, 0);
    dropStart("remu_big_2");
    runDiv("div_7_m2",   1, 0, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33, 0);
    dropStart("div_7_m2");
    runDiv("rem_7_m2",   1, 1, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 33, 0);
    dropStart("rem_7_m2");
    runDiv("rem_m100_m7", 1, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFFE, 33, 0);
    dropStart("rem_m100_m7");
    runDiv("divu_max_1", 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd12, 32'hFFFF_FFFF, 33, 0);
    dropStart("divu_max_1");
    runDiv("divu_5_7",   0, 0, 32'd5, 32'd7, 5'd13, 32'd0, 33, 0);
    dropStart("divu_5_7");

    runDiv("divu_by0",   0, 0, 32'd123, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 0);
    dropStart("divu_by0");
    runDiv("rem_by0",    1, 1, 32'd123, 32'd0, 5'd15, 32'd123, 1, 0);
    dropStart("rem_by0");
    runDiv("div_ovf",    1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
    dropStart("div_ovf");
    runDiv("rem_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, 0);
    dropStart("rem_ovf");

    // back-to-back: second request presented in the cycle right after ready
    runDiv("b2b_first",  0, 1, 32'd100, 32'd7, 5'd18, 32'd2, 33, 0);
    runDiv("b2b_second", 0, 0, 32'd1000, 32'd10, 5'd19, 32'd100, 33, 0);
    dropStart("b2b_second");

    runDiv("isolate",    0, 0, 32'd1000000, 32'd1000, 5'd20, 32'd1000, 33, 1);
    dropStart("isolate");

    // cancel in cycle 10 of CALC
    @(posedge clk); #1;
    applyStimulus(0, 0, 32'd1000, 32'd3, 5'd21);
    repeat (10) begin @(posedge clk); #1; end
    cancel_i = 1'b1;
    start_i  = 1'b0;
    @(negedge clk);
    checkOutput("cancel_stall_now", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    cancel_i = 1'b0;
    @(negedge clk);
    checkOutput("cancel_stall_next", {31'd0, stall_o}, 32'd0);
    watchNoReady("cancel", 40);
    checkOutput("cancel_result_kept", result_o, 32'd1000);

    // reset in cycle 20 of CALC
    @(posedge clk); #1;
    applyStimulus(0, 0, 32'd1000, 32'd3, 5'd22);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_result", result_o, 32'd0);
    checkOutput("midrst_waddr",  {27'd0, waddr_o}, 32'd0);
    watchNoReady("midrst", 40);

    // start and cancel together in IDLE must not be accepted
    @(posedge clk); #1;
    applyStimulus(0, 0, 32'd55, 32'd0, 5'd23);
    cancel_i = 1'b1;
    @(negedge clk);
    checkOutput("startcancel_stall", {31'd0, stall_o}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    start_i  = 1'b0;
    cancel_i = 1'b0;
    watchNoReady("startcancel", 10);
    checkOutput("startcancel_waddr", {27'd0, waddr_o}, 32'd0);

    runDiv("after_rst", 1, 0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd24, 32'd14, 33, 0);
    dropStart("after_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
